// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of one single-port, 1-cycle-latency RAM.
// Define MEMARB_PERF_EN to build the conflict / forced-grant performance counters.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       forced_cnt
);

    typedef enum logic [1:0] {StNone, StIf, StD} owner_e;

    owner_e     owner;
    logic [3:0] starve;
    logic       forced;

    // Fetch overrides data only once it has lost STARVE_MAX cycles in a row.
    assign forced = if_req && d_req && (starve == 4'(STARVE_MAX));
    assign if_gnt = if_req && (!d_req || forced);
    assign d_gnt  = d_req && !forced;

    assign ram_en    = if_gnt | d_gnt;
    assign ram_we    = d_gnt & d_we;
    assign ram_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
    assign ram_wdata = d_gnt ? d_wdata : '0;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            owner  <= StNone;
            starve <= 4'd0;
        end else begin
            if (if_gnt)              owner <= StIf;
            else if (d_gnt && !d_we) owner <= StD;
            else                     owner <= StNone;

            if (!if_req || if_gnt)                 starve <= 4'd0;
            else if (starve != 4'(STARVE_MAX))     starve <= starve + 4'd1;
        end
    end

    assign if_rvalid = (owner == StIf);
    assign d_rvalid  = (owner == StD);
    assign if_rdata  = if_rvalid ? ram_rdata : '0;
    assign d_rdata   = d_rvalid  ? ram_rdata : '0;

`ifdef MEMARB_PERF_EN
    logic [15:0] conflict_q;
    logic [15:0] forced_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            conflict_q <= 16'd0;
            forced_q   <= 16'd0;
        end else begin
            if (if_req && d_req && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
            if (forced && forced_q != 16'hFFFF)            forced_q   <= forced_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign forced_cnt   = forced_q;
`else
    assign conflict_cnt = 16'd0;
    assign forced_cnt   = 16'd0;
`endif

endmodule
